// File: rtl/mfrc_pkg.sv
// mfrc_pkg: shared MFRC522 register map, sequencer state encoding and SPI address-byte helper.
`default_nettype none

package mfrc_pkg;

    localparam logic [5:0] MFRC_REG_COMMAND   = 6'h01;
    localparam logic [5:0] MFRC_REG_COMIEN    = 6'h02;
    localparam logic [5:0] MFRC_REG_FIFODATA  = 6'h09;
    localparam logic [5:0] MFRC_REG_TXCONTROL = 6'h14;
    localparam logic [5:0] MFRC_REG_VERSION   = 6'h37;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR_SEND = 3'd1;
    localparam logic [2:0] ST_ADDR_WAIT = 3'd2;
    localparam logic [2:0] ST_DATA_SEND = 3'd3;
    localparam logic [2:0] ST_DATA_WAIT = 3'd4;
    localparam logic [2:0] ST_RESP      = 3'd5;

    typedef struct packed {
        logic       write;
        logic [5:0] addr;
        logic [7:0] wdata;
    } mfrc_req_t;

    // MSB set means read; the LSB of the address byte is always 0 on this chip.
    function automatic logic [7:0] mfrc_addr_byte(input logic write, input logic [5:0] addr);
        return {~write, addr, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the requester not granted last wins a tie.
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        last_d = last_q;
        if (advance_i && (|req_i)) begin
            last_d = grant_o[1];
        end
    end

    // Starting at 1 lets requester 0 win the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mfrc_reg_sequencer.sv
// mfrc_reg_sequencer: arbitrates two MFRC522 register requesters onto one byte-level
// spi_master, issuing an address byte and a data byte per access with CS held between them.
`default_nettype none

module mfrc_reg_sequencer
    import mfrc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_write,
    input  logic [5:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_rdata,
    output logic       rsp0_err,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_write,
    input  logic [5:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_rdata,
    output logic       rsp1_err,
    output logic       spi_cmd_valid,
    input  logic       spi_cmd_ready,
    output logic [7:0] spi_tx_data,
    output logic       spi_keep_cs,
    input  logic [7:0] spi_rx_data,
    input  logic       spi_cmd_done
);

    localparam int unsigned    TW         = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

    logic [2:0]    state_q, state_d;
    mfrc_req_t     req_q, req_d;
    logic          gid_q, gid_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [1:0]    ready_q, ready_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [1:0]    w_grant;
    logic          w_busy;
    logic          w_expired;
    logic          w_resp;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     ({req1_valid, req0_valid}),
        .advance_i (state_q == ST_IDLE),
        .grant_o   (w_grant)
    );

    assign w_busy = (state_q == ST_ADDR_SEND) || (state_q == ST_ADDR_WAIT) ||
                    (state_q == ST_DATA_SEND) || (state_q == ST_DATA_WAIT);
    // Abort once TIMEOUT_CLKS cycles have been spent in a single send/wait state.
    assign w_expired = w_busy && (timer_q == TIMER_LAST);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        gid_d   = gid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ready_d = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (|w_grant) begin
                    ready_d = w_grant;
                    gid_d   = w_grant[1];
                    req_d   = w_grant[1] ? {req1_write, req1_addr, req1_wdata}
                                         : {req0_write, req0_addr, req0_wdata};
                    rdata_d = 8'h00;
                    err_d   = 1'b0;
                    state_d = ST_ADDR_SEND;
                end
            end
            ST_ADDR_SEND: begin
                if (spi_cmd_ready) begin
                    state_d = ST_ADDR_WAIT;
                end else if (w_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_ADDR_WAIT: begin
                if (spi_cmd_done) begin
                    state_d = ST_DATA_SEND;
                end else if (w_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_DATA_SEND: begin
                if (spi_cmd_ready) begin
                    state_d = ST_DATA_WAIT;
                end else if (w_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_DATA_WAIT: begin
                if (spi_cmd_done) begin
                    if (!req_q.write) begin
                        rdata_d = spi_rx_data;
                    end
                    state_d = ST_RESP;
                end else if (w_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (w_busy) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            gid_q   <= 1'b0;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
            ready_q <= 2'b00;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            gid_q   <= gid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            timer_q <= timer_d;
        end
    end

    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];

    assign spi_cmd_valid = (state_q == ST_ADDR_SEND) || (state_q == ST_DATA_SEND);
    assign spi_keep_cs   = (state_q == ST_ADDR_SEND);
    assign spi_tx_data   = (state_q == ST_ADDR_SEND) ? mfrc_addr_byte(req_q.write, req_q.addr) :
                           ((state_q == ST_DATA_SEND) && req_q.write) ? req_q.wdata : 8'h00;

    assign w_resp     = (state_q == ST_RESP);
    assign rsp0_valid = w_resp && !gid_q;
    assign rsp1_valid = w_resp && gid_q;
    assign rsp0_rdata = rsp0_valid ? rdata_q : 8'h00;
    assign rsp1_rdata = rsp1_valid ? rdata_q : 8'h00;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

endmodule

`default_nettype wire

// File: tb/tb_mfrc_reg_sequencer.sv
// tb_mfrc_reg_sequencer: scoreboard bench with two requester drivers, a byte-level SPI slave model
// and a monitor comparing frames, grants and responses against a transaction-level reference.
`default_nettype none

module tb_mfrc_reg_sequencer;

    typedef struct {
        bit       write;
        bit [5:0] addr;
        bit [7:0] wdata;
        bit       err;
        int       gap;
    } cmd_t;

    typedef struct {
        bit [7:0] tx;
        bit       keep;
        bit [7:0] rx;
    } spi_byte_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rv[2];
    logic       rw[2];
    logic [5:0] ra[2];
    logic [7:0] rwd[2];
    logic       r0_rdy, r1_rdy;
    logic       rsp0_v, rsp1_v, rsp0_err, rsp1_err;
    logic [7:0] rsp0_rd, rsp1_rd;
    logic       spi_valid, spi_ready, spi_keep, spi_done;
    logic [7:0] spi_tx, spi_rx;

    int checks   = 0;
    int failures = 0;

    cmd_t      cmdq[2][$];
    cmd_t      expq[2][$];
    spi_byte_t fr[$];

    int       stall      = 0;
    bit       rnd_stall  = 0;
    bit       rx_fix_en  = 0;
    bit [7:0] rx_fix     = 8'h00;
    int       byte_cnt   = 0;
    int       drop_nth   = -1;
    bit [7:0] last_rdata[2];
    bit       last_err[2];
    bit       last_keep;
    bit       last_cv;

    always #5 clk = ~clk;

    mfrc_reg_sequencer #(.TIMEOUT_CLKS(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (rv[0]),
        .req0_ready    (r0_rdy),
        .req0_write    (rw[0]),
        .req0_addr     (ra[0]),
        .req0_wdata    (rwd[0]),
        .rsp0_valid    (rsp0_v),
        .rsp0_rdata    (rsp0_rd),
        .rsp0_err      (rsp0_err),
        .req1_valid    (rv[1]),
        .req1_ready    (r1_rdy),
        .req1_write    (rw[1]),
        .req1_addr     (ra[1]),
        .req1_wdata    (rwd[1]),
        .rsp1_valid    (rsp1_v),
        .rsp1_rdata    (rsp1_rd),
        .rsp1_err      (rsp1_err),
        .spi_cmd_valid (spi_valid),
        .spi_cmd_ready (spi_ready),
        .spi_tx_data   (spi_tx),
        .spi_keep_cs   (spi_keep),
        .spi_rx_data   (spi_rx),
        .spi_cmd_done  (spi_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic run_req(input int id);
        cmd_t c;
        int   n;
        bit   got;
        rv[id] = 1'b0; rw[id] = 1'b0; ra[id] = '0; rwd[id] = '0;
        forever begin
            while (cmdq[id].size() == 0) begin
                @(posedge clk); #1;
            end
            c = cmdq[id].pop_front();
            repeat (c.gap) begin
                @(posedge clk); #1;
            end
            rv[id] = 1'b1; rw[id] = c.write; ra[id] = c.addr; rwd[id] = c.wdata;
            n = 0; got = 0;
            while (!got && n < 3000) begin
                @(negedge clk);
                if ((id == 0) ? r0_rdy : r1_rdy) got = 1;
                n++;
            end
            if (got) expq[id].push_back(c);
            else chk($sformatf("ready_timeout%0d", id), 0, 1);
            @(posedge clk); #1;
            rv[id] = 1'b0;
        end
    endtask

    initial run_req(0);
    initial run_req(1);

    // SPI slave: accepts a byte on valid&ready, returns done after a short random delay.
    initial begin
        spi_byte_t b;
        bit        acc, rs, busy, cur_drop, drop_this;
        int        cnt;
        bit [7:0]  cur_rx;
        busy = 0; cnt = 0; cur_drop = 0; cur_rx = 0; drop_this = 0;
        spi_ready = 1'b0; spi_done = 1'b0; spi_rx = 8'h00;
        forever begin
            @(negedge clk);
            acc = !rst && !busy && spi_ready && spi_valid;
            rs  = rst;
            if (acc) begin
                b.tx   = spi_tx;
                b.keep = spi_keep;
                b.rx   = rx_fix_en ? rx_fix : 8'($urandom);
                fr.push_back(b);
                drop_this = (byte_cnt == drop_nth);
                byte_cnt++;
            end
            @(posedge clk); #1;
            spi_done = 1'b0;
            spi_rx   = 8'($urandom);
            if (rs) begin
                busy = 0; stall = 0;
            end else if (busy) begin
                if (cnt == 0) begin
                    busy = 0;
                    if (!cur_drop) begin
                        spi_done = 1'b1;
                        spi_rx   = cur_rx;
                    end
                end else begin
                    cnt--;
                end
            end
            if (acc) begin
                busy = 1; cnt = $urandom_range(0, 4); cur_rx = b.rx; cur_drop = drop_this;
            end
            if (stall > 0) stall--;
            else if (rnd_stall && $urandom_range(0, 3) == 0) stall = $urandom_range(1, 4);
            spi_ready = !busy && (stall == 0);
        end
    end

    task automatic handle_rsp(input int id);
        cmd_t      e;
        spi_byte_t b0, b1;
        bit [7:0]  rd, exp_rd, a0;
        bit        er;
        rd = (id == 0) ? rsp0_rd : rsp1_rd;
        er = (id == 0) ? rsp0_err : rsp1_err;
        if (id == 0) chk("rsp_other1", {rsp1_v, rsp1_rd, rsp1_err}, 0);
        else         chk("rsp_other0", {rsp0_v, rsp0_rd, rsp0_err}, 0);
        last_rdata[id] = rd; last_err[id] = er; last_keep = spi_keep; last_cv = spi_valid;
        if (expq[id].size() == 0) begin
            chk($sformatf("rsp_unexpected%0d", id), 1, 0);
            return;
        end
        e = expq[id].pop_front();
        if (fr.size() < (e.err ? 1 : 2)) begin
            chk("frame_bytes", fr.size(), e.err ? 1 : 2);
            return;
        end
        a0 = 8'(int'(e.addr) * 2 + (e.write ? 0 : 128));
        b0 = fr.pop_front();
        chk("addr_byte", {b0.tx, b0.keep}, {a0, 1'b1});
        exp_rd = 8'h00;
        if (!e.err) begin
            b1 = fr.pop_front();
            chk("data_byte", {b1.tx, b1.keep}, {(e.write ? e.wdata : 8'h00), 1'b0});
            if (!e.write) exp_rd = b1.rx;
        end
        chk("rsp_rdata", rd, exp_rd);
        chk("rsp_err", er, e.err);
    endtask

    initial begin
        bit       blt, pv0, pv1, prdy, pend, pkeep;
        bit [7:0] ptx;
        int       act, expg;
        blt = 1; pv0 = 0; pv1 = 0; prdy = 0; pend = 0; pkeep = 0; ptx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                blt = 1; pv0 = 0; pv1 = 0; prdy = 0; pend = 0;
            end else begin
                if (r0_rdy || r1_rdy) begin
                    chk("ready_onehot", r0_rdy & r1_rdy, 0);
                    chk("ready_pulse", prdy, 0);
                    act  = r1_rdy ? 1 : 0;
                    expg = (pv0 && pv1) ? (blt ? 0 : 1) : (pv1 ? 1 : 0);
                    chk("grant", act, expg);
                    blt = (act == 1);
                end
                prdy = r0_rdy | r1_rdy;
                pv0  = rv[0];
                pv1  = rv[1];
                if (pend) chk("cmd_hold", {spi_valid, spi_tx, spi_keep}, {1'b1, ptx, pkeep});
                pend  = spi_valid && !spi_ready;
                ptx   = spi_tx;
                pkeep = spi_keep;
                if (rsp0_v) handle_rsp(0);
                if (rsp1_v) handle_rsp(1);
            end
        end
    end

    task automatic push(input int id, input bit write, input bit [5:0] addr,
                        input bit [7:0] wdata, input bit err, input int gap);
        cmd_t c;
        c.write = write; c.addr = addr; c.wdata = wdata; c.err = err; c.gap = gap;
        cmdq[id].push_back(c);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((cmdq[0].size() + cmdq[1].size() + expq[0].size() + expq[1].size() != 0 ||
                rv[0] || rv[1]) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) chk("idle_timeout", n, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {r0_rdy, r1_rdy, rsp0_v, rsp1_v, rsp0_rd, rsp1_rd, rsp0_err, rsp1_err,
                   spi_valid, spi_tx, spi_keep}, 0);
    endtask

    initial begin
        int target;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;

        // Write COMMAND, then read VERSION with a known returned byte.
        push(0, 1, 6'h01, 8'h0F, 0, 0);
        wait_idle(2000);
        chk("t1_err", last_err[0], 0);
        rx_fix_en = 1; rx_fix = 8'h92;
        push(1, 0, 6'h37, 8'h00, 0, 0);
        wait_idle(2000);
        rx_fix_en = 0;
        chk("t2_rdata", last_rdata[1], 8'h92);

        // Contention: both requesters keep three requests pending.
        for (int i = 0; i < 3; i++) begin
            push(0, 1, 6'h02, 8'(8'h10 + i), 0, 0);
            push(1, 0, 6'h14, 8'h00, 0, 0);
        end
        wait_idle(3000);

        // Backpressure on the address byte.
        stall = 12;
        push(0, 1, 6'h09, 8'hA5, 0, 0);
        wait_idle(2000);

        // Lost completion after a read address byte.
        drop_nth = byte_cnt;
        push(0, 0, 6'h37, 8'h00, 1, 0);
        wait_idle(2000);
        drop_nth = -1;
        chk("t5_err", last_err[0], 1);
        chk("t5_rdata", last_rdata[0], 0);
        chk("t5_spi_idle", {last_cv, last_keep}, 0);

        // Reset while waiting for the data byte.
        drop_nth = byte_cnt + 1;
        target   = byte_cnt + 2;
        push(1, 0, 6'h09, 8'h00, 0, 0);
        n = 0;
        while (byte_cnt < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("t6_wait", n, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("t6_outputs_after_rst");
        expq[1].delete();
        fr.delete();
        drop_nth = -1;
        @(posedge clk); #1;
        push(0, 0, 6'h37, 8'h00, 0, 0);
        push(1, 0, 6'h14, 8'h00, 0, 0);
        wait_idle(2000);

        // Random mixed traffic with random SPI stalls and completion delays.
        rnd_stall = 1;
        for (int i = 0; i < 30; i++) begin
            for (int id = 0; id < 2; id++) begin
                push(id, 1'($urandom), 6'($urandom), 8'($urandom), 0, $urandom_range(0, 3));
            end
        end
        wait_idle(20000);
        rnd_stall = 0;

        chk("frames_drained", fr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
